// File: rtl/led_breath_scheduler.sv
// led_breath_scheduler: 1 ms breathing sequencer with duty ramp, LED mask and mode FSM.
// Ports: w_clk_1ms, w_rst (async, active-low), raw active-low keys w_key_mode and
//   w_key_pause in; duty[9:0], led_en[3:0], mode[1:0], paused, cycle_done out.
// Build option: define LED_BREATH_GAMMA_EN to square the duty output (one tick lag).
module led_breath_scheduler #(
  parameter int unsigned DUTY_MAX    = 999,
  parameter int unsigned STEP        = 1,
  parameter int unsigned DEBOUNCE_MS = 20
) (
  input  logic       w_clk_1ms,
  input  logic       w_rst,
  input  logic       w_key_mode,
  input  logic       w_key_pause,
  output logic [9:0] duty,
  output logic [3:0] led_en,
  output logic [1:0] mode,
  output logic       paused,
  output logic       cycle_done
);

  typedef enum logic [1:0] {
    M_OFF    = 2'd0,
    M_SINGLE = 2'd1,
    M_CHASE  = 2'd2,
    M_ALL    = 2'd3
  } mode_e;

  localparam logic [10:0] MAX11  = 11'(DUTY_MAX);
  localparam logic [10:0] STEP11 = 11'(STEP);
  localparam logic [7:0]  DEB8   = 8'(DEBOUNCE_MS);

  mode_e       mode_q, mode_d;
  logic [9:0]  r_duty_q, r_duty_d;
  logic        dir_up_q, dir_up_d;
  logic [3:0]  sel_q, sel_d;
  logic [3:0]  led_en_q, led_en_d;
  logic        paused_q, paused_d;
  logic        done_q, done_d;
  logic        db_mode_q, db_mode_d;
  logic        db_pause_q, db_pause_d;
  logic [7:0]  cnt_mode_q, cnt_mode_d;
  logic [7:0]  cnt_pause_q, cnt_pause_d;
  logic        press_mode, press_pause;
  logic [10:0] duty11, up_sum;

  // A level is accepted on the sample after the counter has seen
  // DEBOUNCE_MS differing samples; the press pulse fires on that sample.
  always_comb begin
    db_mode_d  = db_mode_q;
    cnt_mode_d = 8'd0;
    press_mode = 1'b0;
    if (w_key_mode != db_mode_q) begin
      if (cnt_mode_q == DEB8) begin
        db_mode_d  = w_key_mode;
        press_mode = ~w_key_mode;
      end else begin
        cnt_mode_d = cnt_mode_q + 8'd1;
      end
    end
  end

  always_comb begin
    db_pause_d  = db_pause_q;
    cnt_pause_d = 8'd0;
    press_pause = 1'b0;
    if (w_key_pause != db_pause_q) begin
      if (cnt_pause_q == DEB8) begin
        db_pause_d  = w_key_pause;
        press_pause = ~w_key_pause;
      end else begin
        cnt_pause_d = cnt_pause_q + 8'd1;
      end
    end
  end

  always_comb begin
    mode_d   = mode_q;
    r_duty_d = r_duty_q;
    dir_up_d = dir_up_q;
    sel_d    = sel_q;
    paused_d = paused_q;
    done_d   = 1'b0;
    led_en_d = 4'b0000;
    duty11   = {1'b0, r_duty_q};
    up_sum   = duty11 + STEP11;
    if (press_mode) begin
      mode_d   = mode_e'(mode_q + 2'd1);
      r_duty_d = '0;
      dir_up_d = 1'b1;
      sel_d    = 4'b0001;
      paused_d = 1'b0;
    end else begin
      if (press_pause && mode_q != M_OFF)
        paused_d = ~paused_q;
      // Gate on the new pause level so a press freezes the current value.
      if (mode_q != M_OFF && !paused_d) begin
        if (dir_up_q) begin
          if (up_sum >= MAX11) begin
            r_duty_d = MAX11[9:0];
            dir_up_d = 1'b0;
          end else begin
            r_duty_d = up_sum[9:0];
          end
        end else if (duty11 <= STEP11) begin
          r_duty_d = '0;
          dir_up_d = 1'b1;
          done_d   = 1'b1;
          if (mode_q == M_CHASE)
            sel_d = {sel_q[2:0], sel_q[3]};
        end else begin
          r_duty_d = 10'(duty11 - STEP11);
        end
      end
    end
    unique case (mode_d)
      M_OFF:    led_en_d = 4'b0000;
      M_SINGLE: led_en_d = sel_d;
      M_CHASE:  led_en_d = sel_d;
      M_ALL:    led_en_d = 4'b1111;
    endcase
  end

  always_ff @(posedge w_clk_1ms or negedge w_rst) begin
    if (!w_rst) begin
      mode_q      <= M_OFF;
      r_duty_q    <= '0;
      dir_up_q    <= 1'b1;
      sel_q       <= 4'b0001;
      led_en_q    <= 4'b0000;
      paused_q    <= 1'b0;
      done_q      <= 1'b0;
      db_mode_q   <= 1'b1;
      db_pause_q  <= 1'b1;
      cnt_mode_q  <= 8'd0;
      cnt_pause_q <= 8'd0;
    end else begin
      mode_q      <= mode_d;
      r_duty_q    <= r_duty_d;
      dir_up_q    <= dir_up_d;
      sel_q       <= sel_d;
      led_en_q    <= led_en_d;
      paused_q    <= paused_d;
      done_q      <= done_d;
      db_mode_q   <= db_mode_d;
      db_pause_q  <= db_pause_d;
      cnt_mode_q  <= cnt_mode_d;
      cnt_pause_q <= cnt_pause_d;
    end
  end

`ifdef LED_BREATH_GAMMA_EN
  logic [9:0] duty_q, duty_d;

  always_comb begin
    duty_d = 10'((20'(r_duty_q) * 20'(r_duty_q)) >> 10);
  end

  always_ff @(posedge w_clk_1ms or negedge w_rst) begin
    if (!w_rst) duty_q <= '0;
    else        duty_q <= duty_d;
  end

  assign duty = duty_q;
`else
  assign duty = r_duty_q;
`endif

  assign led_en     = led_en_q;
  assign mode       = mode_q;
  assign paused     = paused_q;
  assign cycle_done = done_q;

endmodule
